sha2_conduit_regs: RTL and testbench



---
 rtl/sha2_regs_pkg.sv | 29 ++
 rtl/sha2_msg_fifo.sv | 55 +++++
 rtl/sha2_conduit_regs.sv | 225 ++++++++++++++++++++++
 tb/tb_sha2_conduit_regs.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_regs_pkg.sv
// Shared address map, register bit positions and feeder FSM states for the
// SHA2 conduit register bank.
package sha2_regs_pkg;

  localparam logic [11:0] ADDR_CTRL       = 12'h000;
  localparam logic [11:0] ADDR_STATUS     = 12'h004;
  localparam logic [11:0] ADDR_MSG_IN     = 12'h008;
  localparam logic [11:0] ADDR_IRQ_EN     = 12'h00C;
  localparam logic [11:0] ADDR_IRQ_STATUS = 12'h010;
  localparam logic [11:0] ADDR_DIGEST0    = 12'h040;
  localparam logic [11:0] ADDR_DIGEST7    = 12'h05C;

  localparam int CTRL_START    = 0;
  localparam int CTRL_LAST     = 1;
  localparam int CTRL_SOFT_RST = 2;

  localparam int ST_BUSY      = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_EMPTY     = 3;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/sha2_msg_fifo.sv
// Message-word FIFO with wrap-bit pointers and a synchronous clear.
// Caller gates push with !full and pop with !empty.
module sha2_msg_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DW         = 32,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  // The extra wrap bit makes the subtraction exact modulo 2*FIFO_DEPTH.
  assign count = wptr_q - rptr_q;
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (wptr_q == rptr_q);
  assign rdata = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/sha2_conduit_regs.sv
// Conduit-side register bank and SHA-256 message feeder.
// Define SHA2_REGS_IRQ_EN to add IRQ_EN/IRQ_STATUS and the irq output.
module sha2_conduit_regs
  import sha2_regs_pkg::*;
#(
  parameter int D_WIDTH    = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 pclk,
  input  logic                 prst,
  input  logic                 con_wr,
  input  logic                 con_rd,
  input  logic [11:0]          con_waddr,
  input  logic [11:0]          con_raddr,
  input  logic [D_WIDTH-1:0]   con_wdata,
  input  logic [D_WIDTH/8-1:0] con_wbyte_enable,
  output logic                 con_wr_ack,
  output logic [D_WIDTH-1:0]   con_rdata,
  output logic                 con_read_valid,
  output logic                 con_slv_error,
  output logic                 msg_valid,
  input  logic                 msg_ready,
  output logic [31:0]          msg_data,
  output logic                 msg_last,
  input  logic                 digest_valid,
  input  logic [255:0]         digest
`ifdef SHA2_REGS_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e             state_q, state_d;
  logic               last_req_q, last_req_d, done_q, done_d;
  logic [7:0][31:0]   digest_q, digest_d;
  logic               wr_ack_q, wr_ack_d, rd_pend_q, rd_pend_d, rd_err_q, rd_err_d;
  logic               read_valid_q, read_valid_d, slv_err_q, slv_err_d;
  logic [D_WIDTH-1:0] rdata_q, rdata_d;

  logic               fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic               wr_err, rd_err, start, last_set, soft_rst, latch;
  logic [D_WIDTH-1:0] rd_val, status;
`ifdef SHA2_REGS_IRQ_EN
  logic               irq_en_q, irq_en_d, irq_st_q, irq_st_d, irq_q, irq_d;
  logic               irq_en_wr, irq_st_wr;
`endif

  sha2_msg_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DW(32)) u_fifo (
    .clk   (pclk),
    .rst   (prst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (con_wdata[31:0]),
    .rdata (msg_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign msg_valid = (state_q == RUN) && !fifo_empty;
  assign msg_last  = (state_q == RUN) && last_req_q && (fifo_count == CW'(1));
  assign fifo_pop  = msg_valid && msg_ready;

  // Write decode: any error suppresses every side effect of the access.
  always_comb begin
    wr_err    = 1'b0;
    fifo_push = 1'b0;
    start     = 1'b0;
    last_set  = 1'b0;
    soft_rst  = 1'b0;
`ifdef SHA2_REGS_IRQ_EN
    irq_en_wr = 1'b0;
    irq_st_wr = 1'b0;
`endif
    if (con_wr) begin
      case (con_waddr)
        ADDR_CTRL: begin
          if (con_wdata[CTRL_SOFT_RST]) begin
            soft_rst = 1'b1;
          end else begin
            wr_err   = (con_wdata[CTRL_START] && state_q != IDLE) ||
                       (con_wdata[CTRL_LAST]  && state_q != RUN);
            start    = con_wdata[CTRL_START] && !wr_err;
            last_set = con_wdata[CTRL_LAST]  && !wr_err;
          end
        end
        ADDR_MSG_IN: begin
          wr_err    = (con_wbyte_enable != '1) || fifo_full;
          fifo_push = !wr_err;
        end
`ifdef SHA2_REGS_IRQ_EN
        ADDR_IRQ_EN:     irq_en_wr = 1'b1;
        ADDR_IRQ_STATUS: irq_st_wr = 1'b1;
`endif
        default: wr_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    status                     = '0;
    status[ST_BUSY]            = (state_q != IDLE);
    status[ST_DONE]            = done_q;
    status[ST_FULL]            = fifo_full;
    status[ST_EMPTY]           = fifo_empty;
    status[ST_COUNT_LSB +: CW] = fifo_count;
    rd_err = 1'b0;
    rd_val = '0;
    if (con_raddr == ADDR_STATUS)
      rd_val = status;
    else if (con_raddr >= ADDR_DIGEST0 && con_raddr <= ADDR_DIGEST7 && con_raddr[1:0] == 2'b00)
      rd_val = digest_q[3'd7 - con_raddr[4:2]];
`ifdef SHA2_REGS_IRQ_EN
    else if (con_raddr == ADDR_IRQ_EN)
      rd_val = D_WIDTH'(irq_en_q);
    else if (con_raddr == ADDR_IRQ_STATUS)
      rd_val = D_WIDTH'(irq_st_q);
`endif
    else
      rd_err = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    last_req_d = last_req_q;
    done_d     = done_q;
    digest_d   = digest_q;
    fifo_clr   = 1'b0;
    latch      = 1'b0;
    if (soft_rst) begin
      state_d    = IDLE;
      last_req_d = 1'b0;
      done_d     = 1'b0;
      fifo_clr   = 1'b1;
    end else begin
      if (last_set) last_req_d = 1'b1;
      case (state_q)
        IDLE: if (start) begin
          state_d = RUN;
          done_d  = 1'b0;
        end
        RUN:  if (fifo_pop && msg_last) state_d = WAIT;
        WAIT: if (digest_valid) begin
          state_d    = IDLE;
          digest_d   = digest;
          done_d     = 1'b1;
          last_req_d = 1'b0;
          latch      = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Reads take two cycles so the adapter's registered prdata is stable at pready.
  always_comb begin
    wr_ack_d     = con_wr;
    rd_pend_d    = con_rd;
    rd_err_d     = con_rd & rd_err;
    read_valid_d = rd_pend_q;
    slv_err_d    = wr_err | rd_err_q;
    rdata_d      = con_rd ? (rd_err ? '0 : rd_val) : rdata_q;
  end

`ifdef SHA2_REGS_IRQ_EN
  always_comb begin
    irq_en_d = irq_en_q;
    irq_st_d = irq_st_q;
    if (irq_en_wr) irq_en_d = con_wdata[0];
    if (irq_st_wr && con_wdata[0]) irq_st_d = 1'b0;
    if (latch) irq_st_d = 1'b1;
    irq_d = irq_st_q & irq_en_q;
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      irq_en_q <= 1'b0;
      irq_st_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_st_q <= irq_st_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q      <= IDLE;
      last_req_q   <= 1'b0;
      done_q       <= 1'b0;
      digest_q     <= '0;
      wr_ack_q     <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_err_q     <= 1'b0;
      read_valid_q <= 1'b0;
      slv_err_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_req_q   <= last_req_d;
      done_q       <= done_d;
      digest_q     <= digest_d;
      wr_ack_q     <= wr_ack_d;
      rd_pend_q    <= rd_pend_d;
      rd_err_q     <= rd_err_d;
      read_valid_q <= read_valid_d;
      slv_err_q    <= slv_err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign con_wr_ack     = wr_ack_q;
  assign con_read_valid = read_valid_q;
  assign con_slv_error  = slv_err_q;
  assign con_rdata      = rdata_q;

endmodule

// File: tb/tb_sha2_conduit_regs.sv
// Directed + randomized bench for sha2_conduit_regs with a queue-based
// register/FIFO model and a simple SHA core stand-in.
module tb_sha2_conduit_regs;

  logic         pclk = 1'b0;
  logic         prst;
  logic         con_wr, con_rd;
  logic [11:0]  con_waddr, con_raddr;
  logic [31:0]  con_wdata;
  logic [3:0]   con_wbyte_enable;
  logic         con_wr_ack, con_read_valid, con_slv_error;
  logic [31:0]  con_rdata;
  logic         msg_valid, msg_ready, msg_last;
  logic [31:0]  msg_data;
  logic         digest_valid;
  logic [255:0] digest;
`ifdef SHA2_REGS_IRQ_EN
  logic         irq;
`endif

  sha2_conduit_regs dut (
    .pclk(pclk), .prst(prst),
    .con_wr(con_wr), .con_rd(con_rd),
    .con_waddr(con_waddr), .con_raddr(con_raddr),
    .con_wdata(con_wdata), .con_wbyte_enable(con_wbyte_enable),
    .con_wr_ack(con_wr_ack), .con_rdata(con_rdata),
    .con_read_valid(con_read_valid), .con_slv_error(con_slv_error),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_data(msg_data), .msg_last(msg_last),
    .digest_valid(digest_valid), .digest(digest)
`ifdef SHA2_REGS_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 feeding, 2 waiting for the core.
  int           mstate = 0;
  bit           mlast = 0, mdone = 0, mirq_en = 0, mirq_st = 0;
  logic [31:0]  ref_q[$];
  logic [255:0] mdig = '0;

  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s = '0;
    s[0]    = (mstate != 0);
    s[1]    = mdone;
    s[2]    = (ref_q.size() == 16);
    s[3]    = (ref_q.size() == 0);
    s[15:8] = 8'(ref_q.size());
    return s;
  endfunction

  task automatic do_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                       input bit e, input string tag);
    con_waddr = a; con_wdata = d; con_wbyte_enable = be; con_wr = 1'b1;
    tick();
    con_wr = 1'b0;
    chk({tag, "_ack"}, con_wr_ack, 1);
    chk({tag, "_err"}, con_slv_error, e);
  endtask

  task automatic wr_m(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                      input string tag);
    bit e = 0;
    if (a == 12'h000) begin
      if (d[2]) begin
        ref_q.delete(); mstate = 0; mlast = 0; mdone = 0;
      end else begin
        e = (d[0] && mstate != 0) || (d[1] && mstate != 1);
        if (!e && d[0]) begin mstate = 1; mdone = 0; end
        if (!e && d[1]) mlast = 1;
      end
    end else if (a == 12'h008) begin
      e = (be != 4'hF) || (ref_q.size() >= 16);
      if (!e) ref_q.push_back(d);
    end
`ifdef SHA2_REGS_IRQ_EN
    else if (a == 12'h00C) mirq_en = d[0];
    else if (a == 12'h010) begin if (d[0]) mirq_st = 0; end
`endif
    else e = 1;
    do_wr(a, d, be, e, tag);
  endtask

  task automatic rd_m(input logic [11:0] a, input string tag);
    logic [31:0] ex = '0;
    bit e = 0;
    int idx;
    if (a == 12'h004) ex = exp_status();
    else if (a >= 12'h040 && a <= 12'h05C && a[1:0] == 2'b00) begin
      idx = int'((a - 12'h040) >> 2);
      ex  = mdig[255 - 32*idx -: 32];
    end
`ifdef SHA2_REGS_IRQ_EN
    else if (a == 12'h00C) ex = {31'b0, mirq_en};
    else if (a == 12'h010) ex = {31'b0, mirq_st};
`endif
    else e = 1;
    con_raddr = a; con_rd = 1'b1;
    tick();
    con_rd = 1'b0;
    chk({tag, "_early"}, con_read_valid, 0);
    tick();
    chk({tag, "_valid"}, con_read_valid, 1);
    chk({tag, "_err"}, con_slv_error, e);
    chk({tag, "_data"}, con_rdata, ex);
  endtask

  // Core stand-in: random backpressure, digest three cycles after the last word.
  task automatic run_core(input logic [255:0] dig, input string tag);
    int cyc = 0;
    int wc = 0;
    while (mstate != 0 && cyc < 800) begin
      msg_ready    = 1'($urandom_range(0, 1));
      digest_valid = 1'b0;
      chk({tag, "_mvalid"}, msg_valid, (mstate == 1 && ref_q.size() > 0));
      chk({tag, "_mlast"}, msg_last, (mstate == 1 && mlast && ref_q.size() == 1));
      if (mstate == 1 && ref_q.size() > 0) chk({tag, "_mdata"}, msg_data, ref_q[0]);
      if (mstate == 1 && ref_q.size() > 0 && msg_ready) begin
        if (mlast && ref_q.size() == 1) mstate = 2;
        void'(ref_q.pop_front());
      end else if (mstate == 2) begin
        wc++;
        if (wc == 3) begin
          digest_valid = 1'b1; digest = dig;
          mstate = 0; mdone = 1; mlast = 0; mdig = dig; mirq_st = 1;
        end
      end
      tick();
      cyc++;
    end
    digest_valid = 1'b0;
    msg_ready    = 1'b0;
    chk({tag, "_in_budget"}, (cyc < 800), 1);
  endtask

  task automatic rand_msg(input string tag);
    int n = $urandom_range(1, 18);
    logic [255:0] dg;
    for (int k = 0; k < 8; k++) dg[32*k +: 32] = $urandom();
    for (int i = 0; i < n; i++)
      wr_m(12'h008, $urandom(), (i > 0 && $urandom_range(0, 5) == 0) ? 4'h7 : 4'hF, {tag, "_push"});
    wr_m(12'h000, 32'h1, 4'hF, {tag, "_start"});
    rd_m(12'h004, {tag, "_st_busy"});
    rd_m(12'h040 + 12'(4 * $urandom_range(0, 7)), {tag, "_dig_busy"});
    wr_m(12'h000, 32'h2, 4'hF, {tag, "_last"});
    run_core(dg, tag);
    rd_m(12'h004, {tag, "_st_done"});
    rd_m(12'h040 + 12'(4 * $urandom_range(0, 7)), {tag, "_dig"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    con_wr = 0; con_rd = 0; con_waddr = '0; con_raddr = '0; con_wdata = '0;
    con_wbyte_enable = '0; msg_ready = 0; digest_valid = 0; digest = '0;
    prst = 1'b1;
    repeat (3) tick();
    chk("rst_wr_ack", con_wr_ack, 0);
    chk("rst_rvalid", con_read_valid, 0);
    chk("rst_err", con_slv_error, 0);
    chk("rst_rdata", con_rdata, 0);
    chk("rst_mvalid", msg_valid, 0);
    chk("rst_mlast", msg_last, 0);
    prst = 1'b0;
    tick();

    rd_m(12'h004, "status_reset");
    chk("status_reset_lit", con_rdata, 32'h0000_0008);
    rd_m(12'h040, "digest0_reset");

    for (int i = 0; i < 16; i++) wr_m(12'h008, 32'(i), 4'hF, "fill");
    wr_m(12'h008, 32'h10, 4'hF, "push_full");
    rd_m(12'h004, "status_full");
    chk("status_full_lit", con_rdata, 32'h0000_1004);

    rd_m(12'h000, "rd_ctrl");
    rd_m(12'h008, "rd_msg_in");
    wr_m(12'h004, 32'h1, 4'hF, "wr_status");
    wr_m(12'h044, 32'h1, 4'hF, "wr_digest");
    rd_m(12'h0FC, "rd_unmapped");
    rd_m(12'h041, "rd_unaligned");
    wr_m(12'h000, 32'h2, 4'hF, "last_idle");
    wr_m(12'h00C, 32'h1, 4'hF, "wr_irq_en");
    rd_m(12'h010, "rd_irq_st");

    wr_m(12'h000, 32'h4, 4'hF, "soft_rst");
    rd_m(12'h004, "status_after_srst");
    wr_m(12'h008, 32'hDEAD, 4'h7, "partial_strobe");
    rd_m(12'h004, "status_after_partial");

    // One-block "abc" message.
    wr_m(12'h008, 32'h6162_6380, 4'hF, "abc_push");
    for (int i = 1; i < 15; i++) wr_m(12'h008, 32'h0, 4'hF, "abc_push");
    wr_m(12'h008, 32'h0000_0018, 4'hF, "abc_push");
    wr_m(12'h000, 32'h1, 4'hF, "abc_start");
    rd_m(12'h004, "abc_status_run");
    wr_m(12'h000, 32'h1, 4'hF, "start_busy");
    rd_m(12'h004, "status_after_start_busy");
    wr_m(12'h000, 32'h2, 4'hF, "abc_last");
    run_core(ABC_DIG, "abc");
    rd_m(12'h004, "abc_status_done");
    chk("abc_status_lit", con_rdata, 32'h0000_000A);
    for (int i = 0; i < 8; i++) rd_m(12'h040 + 12'(4 * i), "abc_digest");
    rd_m(12'h040, "abc_d0");
    chk("abc_d0_lit", con_rdata, 32'hBA78_16BF);
    rd_m(12'h05C, "abc_d7");
    chk("abc_d7_lit", con_rdata, 32'hF200_15AD);

    digest_valid = 1'b1; digest = {8{32'h5A5A_A5A5}};
    tick();
    digest_valid = 1'b0;
    rd_m(12'h040, "digest_ignored_idle");

    for (int r = 0; r < 4; r++) rand_msg("rnd");

    for (int i = 0; i < 5; i++) wr_m(12'h008, $urandom(), 4'hF, "mid_push");
    wr_m(12'h000, 32'h1, 4'hF, "mid_start");
    wr_m(12'h000, 32'h4, 4'hF, "mid_srst");
    rd_m(12'h004, "mid_status");
    chk("mid_status_lit", con_rdata, 32'h0000_0008);
    rd_m(12'h040, "mid_digest_kept");
    wr_m(12'h000, 32'h5, 4'hF, "srst_start");
    rd_m(12'h004, "srst_start_status");

`ifdef SHA2_REGS_IRQ_EN
    wr_m(12'h00C, 32'h1, 4'hF, "irq_en_set");
    rd_m(12'h00C, "irq_en_rd");
    wr_m(12'h008, 32'h1234, 4'hF, "irq_push");
    wr_m(12'h000, 32'h1, 4'hF, "irq_start");
    wr_m(12'h000, 32'h2, 4'hF, "irq_last");
    chk("irq_low_run", irq, 0);
    run_core(ABC_DIG, "irq_msg");
    chk("irq_same_cycle_as_done", irq, 0);
    tick();
    chk("irq_rises", irq, 1);
    rd_m(12'h010, "irq_st_rd");
    wr_m(12'h010, 32'h1, 4'hF, "irq_w1c");
    tick();
    chk("irq_cleared", irq, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
